fabric_config_loader: RTL

Bitstream loader that drives the fabric configuration shift chain (`cen`, `shift_in`, `set_in`) threaded through every connection block, switch box and CLB tile. It accepts configuration words over a valid/ready stream, serializes them LSB-first into the chain, then pulses `set_in` to commit the shifted bits. It also deserializes the bits returning on the chain tail (`shift_out` of the last tile) into readback words. It sits between the SoC-side config port (Wishbone slave or scan controller) and the head of the fabric chain.

---
 rtl/fabric_cfg_pkg.sv | 18 +
 rtl/cfg_readback_deser.sv | 62 ++++++
 rtl/fabric_config_loader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for the fabric configuration loader and the SoC-side config-port wrapper.
package fabric_cfg_pkg;

    localparam int WORD_W_DEFAULT = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_SHIFT  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        FETCH  = ST_FETCH,
        SHIFT  = ST_SHIFT,
        COMMIT = ST_COMMIT
    } state_t;

endpackage

// File: rtl/cfg_readback_deser.sv
// Collects bits returning from the chain tail into readback words, bit 0 first.
module cfg_readback_deser #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en_i,
    input  logic              sample_bit_i,
    input  logic              sample_last_i,
    output logic [WORD_W-1:0] rb_data_o,
    output logic              rb_valid_o
);

    localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [IW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] acc_next;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        idx_d    = idx_q;
        acc_d    = acc_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        acc_next = acc_q;
        if (sample_en_i) begin
            acc_next[idx_q] = sample_bit_i;
            if (sample_last_i || (idx_q == IW'(WORD_W - 1))) begin
                // Accumulator restarts empty, so a partial final word reads 0 above its last bit.
                data_d  = acc_next;
                valid_d = 1'b1;
                acc_d   = '0;
                idx_d   = '0;
            end else begin
                acc_d = acc_next;
                idx_d = idx_q + IW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign rb_data_o  = data_q;
    assign rb_valid_o = valid_q;

endmodule

// File: rtl/fabric_config_loader.sv
// Streams config words LSB-first into the fabric shift chain, commits with set_in, and reads the tail back.
module fabric_config_loader
    import fabric_cfg_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEFAULT,
    parameter int CHAIN_LEN = 300,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cen,
    output logic              shift_in,
    output logic              set_in,
    input  logic              chain_out,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);

    localparam int BW = $clog2(WORD_W + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [BW-1:0]     bits_q, bits_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              done_q, done_d;

    logic shift_cycle;
    logic last_bit;

    assign shift_cycle = (state_q == SHIFT);
    assign last_bit    = shift_cycle && (remaining_q == CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        bits_d      = bits_q;
        shreg_d     = shreg_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = FETCH;
                    remaining_d = CNT_W'(CHAIN_LEN);
                end
            end
            FETCH: begin
                if (word_valid) begin
                    shreg_d = word_data;
                    // The final word may be partial; its upper bits are simply never shifted.
                    if (int'(remaining_q) >= WORD_W) begin
                        bits_d = BW'(WORD_W);
                    end else begin
                        bits_d = BW'(remaining_q);
                    end
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d     = shreg_q >> 1;
                remaining_d = remaining_q - CNT_W'(1);
                bits_d      = bits_q - BW'(1);
                if (bits_q == BW'(1)) begin
                    state_d = (remaining_q == CNT_W'(1)) ? COMMIT : FETCH;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the word shift register is cleared on reset too, so no stale config is ever replayed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            bits_q      <= '0;
            shreg_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            bits_q      <= bits_d;
            shreg_q     <= shreg_d;
            done_q      <= done_d;
        end
    end

    // Chain controls decode from registered state only, so reset forces them low immediately.
    assign word_ready = (state_q == FETCH);
    assign cen        = shift_cycle;
    assign shift_in   = shift_cycle & shreg_q[0];
    assign set_in     = (state_q == COMMIT);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

    cfg_readback_deser #(
        .WORD_W(WORD_W)
    ) u_readback (
        .clk          (clk),
        .rst          (rst),
        .sample_en_i  (shift_cycle),
        .sample_bit_i (chain_out),
        .sample_last_i(last_bit),
        .rb_data_o    (rb_data),
        .rb_valid_o   (rb_valid)
    );

    a_chain_excl: assert property (@(posedge clk) disable iff (rst) !(cen && set_in));
    a_shift_quiet: assert property (@(posedge clk) disable iff (rst) (!cen) |-> !shift_in);

endmodule
